// File: rtl/cache_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : cache_pkg                                               |
// | Purpose  : Shared types and constants for the L1 refill sequencer. |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
package cache_pkg;

    typedef enum logic [2:0] {
        INIT     = 3'd0,
        CHECK    = 3'd1,
        WB_LOAD  = 3'd2,
        WB_STORE = 3'd3,
        FETCH    = 3'd4,
        FILL     = 3'd5
    } refill_state_t;

    localparam logic SRC_MM = 1'b0;
    localparam logic SRC_L1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : rr_arbiter                                              |
// | Purpose  : Combinational round-robin / fixed-priority arbiter.     |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module rr_arbiter #(
    parameter int N    = 2,
    parameter int MODE = 0,
    parameter int PW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt_onehot,
    output logic [PW-1:0] o_gnt_idx,
    output logic          o_any
);

    int            w_base;
    logic [PW-1:0] w_sel;

    // Scan upward from the start point; the first requester found wins.
    always_comb begin
        o_gnt_onehot = '0;
        o_gnt_idx    = '0;
        o_any        = 1'b0;
        w_base       = 0;
        w_sel        = '0;
        if (MODE == 0) begin
            w_base = int'(i_ptr);
        end
        for (int off = 0; off < N; off++) begin
            w_sel = PW'((w_base + off) % N);
            if (!o_any && i_req[w_sel]) begin
                o_any               = 1'b1;
                o_gnt_idx           = w_sel;
                o_gnt_onehot[w_sel] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_refill_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : cache_refill_ctrl                                       |
// | Purpose  : N-port L1 refill / write-back sequencer.                |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module cache_refill_ctrl
    import cache_pkg::*;
#(
    parameter  int NUM_PORTS      = 2,
    parameter  int WORDS_PER_LINE = 8,
    parameter  int ARB_MODE       = 0,
    localparam int PORT_W         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    localparam int WIDX_W         = $clog2(WORDS_PER_LINE)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_PORTS-1:0] req_rd,
    input  logic [NUM_PORTS-1:0] req_wr,
    input  logic [NUM_PORTS-1:0] hit,
    input  logic [NUM_PORTS-1:0] dirty,
    input  logic                 mem_valid_mm,
    output logic                 clr,
    output logic [NUM_PORTS-1:0] mem_valid,
    output logic [NUM_PORTS-1:0] we_l1,
    output logic [PORT_W-1:0]    sel_port,
    output logic                 sel_src,
    output logic [WIDX_W-1:0]    word_idx,
    output logic                 we_cl,
    output logic                 re_mm,
    output logic                 we_mm,
    output logic                 busy
);

    refill_state_t        r_state, w_state_nxt;
    logic [WIDX_W-1:0]    r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [PORT_W-1:0]    r_grant, w_grant_nxt;
    logic [PORT_W-1:0]    r_rr_ptr, w_rr_ptr_nxt;
    logic                 r_wb_pend, w_wb_pend_nxt;
    logic                 w_last;
    logic [NUM_PORTS-1:0] w_req, w_miss, w_arb_onehot;
    logic [PORT_W-1:0]    w_arb_idx, w_arb_idx_inc;
    logic                 w_arb_any;

    assign w_req         = req_rd | req_wr;
    assign w_miss        = w_req & ~hit;
    assign w_last        = (r_cnt == WIDX_W'(WORDS_PER_LINE - 1));
    assign w_cnt_inc     = r_cnt + WIDX_W'(1);
    assign w_arb_idx_inc = (w_arb_idx == PORT_W'(NUM_PORTS - 1)) ? '0 : w_arb_idx + PORT_W'(1);

    rr_arbiter #(
        .N    (NUM_PORTS),
        .MODE (ARB_MODE),
        .PW   (PORT_W)
    ) u_arb (
        .i_req        (w_miss),
        .i_ptr        (r_rr_ptr),
        .o_gnt_onehot (w_arb_onehot),
        .o_gnt_idx    (w_arb_idx),
        .o_any        (w_arb_any)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= INIT;
            r_cnt     <= '0;
            r_grant   <= '0;
            r_rr_ptr  <= '0;
            r_wb_pend <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_grant   <= w_grant_nxt;
            r_rr_ptr  <= w_rr_ptr_nxt;
            r_wb_pend <= w_wb_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_grant_nxt   = r_grant;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_wb_pend_nxt = r_wb_pend;
        clr           = 1'b0;
        mem_valid     = '0;
        we_l1         = '0;
        sel_port      = r_grant;
        sel_src       = SRC_MM;
        word_idx      = r_cnt;
        we_cl         = 1'b0;
        re_mm         = 1'b0;
        we_mm         = 1'b0;
        busy          = 1'b0;

        case (r_state)
            INIT: begin
                clr         = 1'b1;
                sel_port    = '0;
                word_idx    = '0;
                w_state_nxt = CHECK;
            end
            CHECK: begin
                // Hits on every port are served even while a miss is granted.
                mem_valid = w_req & hit;
                if (w_arb_any) begin
                    w_grant_nxt   = w_arb_idx;
                    w_rr_ptr_nxt  = w_arb_idx_inc;
                    w_wb_pend_nxt = |(dirty & w_arb_onehot);
                    w_cnt_nxt     = '0;
                    w_state_nxt   = (|(dirty & w_arb_onehot)) ? WB_LOAD : FETCH;
                end
            end
            WB_LOAD: begin
                busy    = 1'b1;
                sel_src = SRC_L1;
                we_cl   = 1'b1;
                if (w_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = r_wb_pend ? WB_STORE : FETCH;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            WB_STORE: begin
                busy  = 1'b1;
                we_mm = 1'b1;
                if (mem_valid_mm) begin
                    if (w_last) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = FETCH;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end
            FETCH: begin
                busy  = 1'b1;
                re_mm = 1'b1;
                we_cl = mem_valid_mm;
                if (mem_valid_mm) begin
                    if (w_last) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = FILL;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end
            FILL: begin
                busy  = 1'b1;
                we_l1 = NUM_PORTS'(1) << r_grant;
                if (w_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = CHECK;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = INIT;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_refill_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_cache_refill_ctrl                                    |
// | Purpose  : Directed self-checking bench for cache_refill_ctrl.     |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module tb_cache_refill_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] req_rd, req_wr, hit, dirty;
    logic       mem_valid_mm;

    logic       clr, sel_src, we_cl, re_mm, we_mm, busy;
    logic [1:0] mem_valid, we_l1;
    logic       sel_port;
    logic [2:0] word_idx;

    logic       fp_clr, fp_sel_src, fp_we_cl, fp_re_mm, fp_we_mm, fp_busy;
    logic [1:0] fp_mem_valid, fp_we_l1;
    logic       fp_sel_port;
    logic [2:0] fp_word_idx;

    int vectors = 0;
    int miscompares = 0;
    int n, k, nload, nwm, nrm, nfill;
    logic ph;

    always #5 clk = ~clk;

    cache_refill_ctrl #(.NUM_PORTS(2), .WORDS_PER_LINE(8), .ARB_MODE(0)) dut (
        .clk(clk), .reset_n(reset_n), .req_rd(req_rd), .req_wr(req_wr), .hit(hit),
        .dirty(dirty), .mem_valid_mm(mem_valid_mm), .clr(clr), .mem_valid(mem_valid),
        .we_l1(we_l1), .sel_port(sel_port), .sel_src(sel_src), .word_idx(word_idx),
        .we_cl(we_cl), .re_mm(re_mm), .we_mm(we_mm), .busy(busy)
    );

    cache_refill_ctrl #(.NUM_PORTS(2), .WORDS_PER_LINE(8), .ARB_MODE(1)) dut_fp (
        .clk(clk), .reset_n(reset_n), .req_rd(req_rd), .req_wr(req_wr), .hit(hit),
        .dirty(dirty), .mem_valid_mm(mem_valid_mm), .clr(fp_clr), .mem_valid(fp_mem_valid),
        .we_l1(fp_we_l1), .sel_port(fp_sel_port), .sel_src(fp_sel_src), .word_idx(fp_word_idx),
        .we_cl(fp_we_cl), .re_mm(fp_re_mm), .we_mm(fp_we_mm), .busy(fp_busy)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0; req_rd = '0; req_wr = '0; hit = '0; dirty = '0; mem_valid_mm = 1'b0;

        // 1) reset, single-cycle clear, idle CHECK
        tick();
        tick();
        #1;
        chk("t1_rst_clr", clr, 1);
        chk("t1_rst_re_mm", re_mm, 0);
        chk("t1_rst_sel_port", sel_port, 0);
        chk("t1_rst_word_idx", word_idx, 0);
        reset_n = 1'b1;
        #1;
        chk("t1_init_clr", clr, 1);
        tick();
        #1;
        chk("t1_check_clr", clr, 0);
        chk("t1_check_busy", busy, 0);
        chk("t1_check_mem_valid", mem_valid, 0);
        chk("t1_check_strobes", {we_cl, re_mm, we_mm, we_l1}, 0);

        // 2) both ports hit in the same cycle
        req_rd = 2'b11; hit = 2'b11;
        #1;
        chk("t2_mem_valid", mem_valid, 2'b11);
        tick();
        #1;
        chk("t2_mem_valid_held", mem_valid, 2'b11);
        chk("t2_busy", busy, 0);

        // 3) clean miss on port 1, memory accepting every other cycle
        req_rd = 2'b10; hit = 2'b00; dirty = 2'b00;
        #1;
        chk("t3_miss_mem_valid", mem_valid, 0);
        tick();
        #1;
        chk("t3_fetch_re_mm", re_mm, 1);
        chk("t3_fetch_sel_port", sel_port, 1);
        chk("t3_fetch_busy", busy, 1);
        chk("t3_fetch_sel_src", sel_src, 0);
        ph = 1'b0; k = 0; n = 0;
        while (n < 60) begin
            mem_valid_mm = ph;
            #1;
            if (!re_mm) break;
            if (ph) begin
                chk("t3_word_idx", word_idx, k);
                chk("t3_we_cl", we_cl, 1);
                k++;
            end else begin
                chk("t3_stall_we_cl", we_cl, 0);
            end
            tick();
            ph = ~ph;
            n++;
        end
        chk("t3_words_fetched", k, 8);
        mem_valid_mm = 1'b0;
        for (int j = 0; j < 8; j++) begin
            #1;
            chk("t3_fill_we_l1", we_l1, 2'b10);
            chk("t3_fill_word_idx", word_idx, j);
            tick();
        end
        hit = 2'b10;
        #1;
        chk("t3_after_fill_mem_valid", mem_valid, 2'b10);
        chk("t3_after_fill_busy", busy, 0);
        req_rd = 2'b00; hit = 2'b00;

        // 4) dirty write miss on port 0, memory always ready
        req_wr = 2'b01; dirty = 2'b01; mem_valid_mm = 1'b1;
        tick();
        #1;
        chk("t4_wbload_sel_src", sel_src, 1);
        chk("t4_wbload_we_cl", we_cl, 1);
        chk("t4_wbload_sel_port", sel_port, 0);
        n = 0; nload = 0; nwm = 0; nrm = 0; nfill = 0;
        while (busy && n < 100) begin
            if (sel_src && we_cl) nload++;
            if (we_mm && mem_valid_mm) nwm++;
            if (re_mm && mem_valid_mm) nrm++;
            if (we_l1 == 2'b01) nfill++;
            tick();
            #1;
            n++;
        end
        chk("t4_total_cycles", n, 32);
        chk("t4_wb_load_words", nload, 8);
        chk("t4_wb_store_words", nwm, 8);
        chk("t4_fetch_words", nrm, 8);
        chk("t4_fill_words", nfill, 8);
        dirty = 2'b00; hit = 2'b01;
        #1;
        chk("t4_after_fill_mem_valid", mem_valid, 2'b01);
        req_wr = 2'b00; hit = 2'b00;

        // 5) both ports miss continuously: rotation vs fixed priority
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        req_rd = 2'b11; mem_valid_mm = 1'b1;
        for (int g = 0; g < 4; g++) begin
            #1;
            chk("t5_check_busy", busy, 0);
            tick();
            #1;
            chk("t5_rr_grant", sel_port, g % 2);
            chk("t5_fp_grant", fp_sel_port, 0);
            n = 0;
            while (busy && n < 50) begin
                tick();
                #1;
                n++;
            end
            chk("t5_refill_cycles", n, 16);
        end

        // 6) reset in the middle of a fetch
        req_rd = 2'b01;
        tick();
        tick();
        tick();
        tick();
        #1;
        chk("t6_fetch_word_idx", word_idx, 3);
        chk("t6_fetch_re_mm", re_mm, 1);
        reset_n = 1'b0;
        tick();
        #1;
        chk("t6_abort_clr", clr, 1);
        chk("t6_abort_re_mm", re_mm, 0);
        chk("t6_abort_word_idx", word_idx, 0);
        chk("t6_abort_we_l1", we_l1, 0);
        chk("t6_abort_sel_port", sel_port, 0);
        reset_n = 1'b1; req_rd = 2'b00; mem_valid_mm = 1'b0;
        tick();
        #1;
        chk("t6_recover_clr", clr, 0);
        chk("t6_recover_busy", busy, 0);
        tick();
        #1;
        chk("t6_idle_we_l1", we_l1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
